// File: rtl/breakout_renderer_if.sv
// Pixel stream from the breakout renderer to the LCD SPI writer.
// Latency: n/a (wires only); one pixel moves per cycle when pix_valid && pix_ready.
// Backpressure: pix_ready low holds the current pixel and its markers stable.
//   pix_valid  master->slave  pixel present
//   pix_ready  slave->master  pixel accepted this cycle
//   pix_data   master->slave  RGB565 colour
//   pix_first  master->slave  marks pixel (0,0)
//   pix_last   master->slave  marks pixel (GAME_W-1,GAME_H-1)
interface breakout_renderer_if;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_data;
  logic        pix_first;
  logic        pix_last;

  modport master (
    output pix_valid,
    output pix_data,
    output pix_first,
    output pix_last,
    input  pix_ready
  );

  modport slave (
    input  pix_valid,
    input  pix_data,
    input  pix_first,
    input  pix_last,
    output pix_ready
  );
endinterface

// File: rtl/breakout_renderer.sv
// Snapshots breakout game state on frame_start and streams one raster frame of RGB565 pixels.
// Latency: 10 BCD-conversion cycles after frame_start, then up to 1 pixel per cycle.
// Backpressure: pix_ready low freezes the raster counters, so the presented pixel holds.
//   clk, reset_n        clock, async active-low reset (aborts a frame without frame_done)
//   frame_start         render request, ignored while busy
//   paddle_x .. ball_lost  live game state, captured only on an accepted frame_start
//   busy, frame_done    frame in progress / 1-cycle pulse after the last pixel transfer
//   pix                 pixel stream master (valid/ready, data, first/last markers)
module breakout_renderer #(
  parameter int GAME_W = 320,
  parameter int GAME_H = 240
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                frame_start,
  input  logic [8:0]          paddle_x,
  input  logic [8:0]          ball_x_pix,
  input  logic [8:0]          ball_y_pix,
  input  logic [47:0]         bricks_alive,
  input  logic [9:0]          score,
  input  logic                ball_lost,
  output logic                busy,
  output logic                frame_done,
  breakout_renderer_if.master pix
);

  localparam int XW = $clog2(GAME_W);
  localparam int YW = $clog2(GAME_H);
  localparam logic [XW-1:0] X_LAST = XW'(GAME_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(GAME_H - 1);

  typedef enum logic [1:0] {S_IDLE, S_CONVERT, S_STREAM, S_DONE} state_t;

  state_t        r_state;
  state_t        w_state_nxt;

  // Snapshot of the game state for the frame being drawn.
  logic [8:0]    r_paddle_x;
  logic [8:0]    r_ball_x;
  logic [8:0]    r_ball_y;
  logic [47:0]   r_bricks;
  logic          r_ball_lost;

  // Double-dabble: binary shifts out MSB first into the BCD register.
  logic [9:0]    r_bin;
  logic [15:0]   r_bcd;
  logic [3:0]    r_dd_cnt;
  logic [15:0]   w_bcd_adj;

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;

  logic          w_pix_valid;
  logic          w_xfer;
  logic          w_at_last;

  int            w_xi;
  int            w_yi;
  int            w_px;
  int            w_bx;
  int            w_by;

  logic          w_ball_hit;
  logic          w_paddle_hit;
  logic          w_digit_lit;
  logic          w_col_hit;
  logic          w_row_hit;
  logic [2:0]    w_col;
  logic [2:0]    w_row;
  logic          w_brick_hit;
  logic [15:0]   w_colour;

  // Segment bits ordered {a,b,c,d,e,f,g}.
  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_decode = 7'b1111110;
      4'd1:    seg_decode = 7'b0110000;
      4'd2:    seg_decode = 7'b1101101;
      4'd3:    seg_decode = 7'b1111001;
      4'd4:    seg_decode = 7'b0110011;
      4'd5:    seg_decode = 7'b1011011;
      4'd6:    seg_decode = 7'b1011111;
      4'd7:    seg_decode = 7'b1110000;
      4'd8:    seg_decode = 7'b1111111;
      4'd9:    seg_decode = 7'b1111011;
      default: seg_decode = 7'b0000000;
    endcase
  endfunction

  // (u,v) is already known to lie inside the 10x16 cell.
  function automatic logic seg_hit(input logic [6:0] segs, input int u, input int v);
    seg_hit = (segs[6] && v <= 1 && u >= 1 && u <= 8)
           || (segs[5] && u >= 8 && v >= 1 && v <= 7)
           || (segs[4] && u >= 8 && v >= 8 && v <= 14)
           || (segs[3] && v >= 14 && u >= 1 && u <= 8)
           || (segs[2] && u <= 1 && v >= 8 && v <= 14)
           || (segs[1] && u <= 1 && v >= 1 && v <= 7)
           || (segs[0] && v >= 7 && v <= 8 && u >= 1 && u <= 8);
  endfunction

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pix_valid = 1'b0;
    busy        = 1'b0;
    frame_done  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (frame_start) w_state_nxt = S_CONVERT;
      end
      S_CONVERT: begin
        busy = 1'b1;
        if (r_dd_cnt == 4'd9) w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        busy        = 1'b1;
        w_pix_valid = 1'b1;
        if (pix.pix_ready && w_at_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        frame_done  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_xfer    = w_pix_valid && pix.pix_ready;
  assign w_at_last = (r_x == X_LAST) && (r_y == Y_LAST);

  always_comb begin
    w_bcd_adj = r_bcd;
    for (int n = 0; n < 4; n++) begin
      if (r_bcd[4*n +: 4] >= 4'd5) w_bcd_adj[4*n +: 4] = r_bcd[4*n +: 4] + 4'd3;
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_paddle_x  <= '0;
      r_ball_x    <= '0;
      r_ball_y    <= '0;
      r_bricks    <= '0;
      r_ball_lost <= 1'b0;
      r_bin       <= '0;
      r_bcd       <= '0;
      r_dd_cnt    <= '0;
      r_x         <= '0;
      r_y         <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_paddle_x  <= paddle_x;
            r_ball_x    <= ball_x_pix;
            r_ball_y    <= ball_y_pix;
            r_bricks    <= bricks_alive;
            r_ball_lost <= ball_lost;
            r_bin       <= score;
            r_bcd       <= '0;
            r_dd_cnt    <= '0;
            r_x         <= '0;
            r_y         <= '0;
          end
        end
        S_CONVERT: begin
          r_bcd    <= {w_bcd_adj[14:0], r_bin[9]};
          r_bin    <= {r_bin[8:0], 1'b0};
          r_dd_cnt <= r_dd_cnt + 4'd1;
        end
        S_STREAM: begin
          if (w_xfer) begin
            if (r_x == X_LAST) begin
              r_x <= '0;
              r_y <= r_y + 1'b1;
            end else begin
              r_x <= r_x + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- pixel colour for (r_x, r_y) ----------------
  // Geometry runs in 32-bit signed ints so the paddle's left edge can go negative.
  assign w_xi = int'(r_x);
  assign w_yi = int'(r_y);
  assign w_px = int'(r_paddle_x);
  assign w_bx = int'(r_ball_x);
  assign w_by = int'(r_ball_y);

  assign w_ball_hit   = (w_xi >= w_bx) && (w_xi <= w_bx + 7) && (w_yi >= w_by) && (w_yi <= w_by + 7);
  assign w_paddle_hit = (w_xi >= w_px - 16) && (w_xi <= w_px + 15) && (w_yi >= 210) && (w_yi <= 218);

  // Column and row are resolved independently, then the alive mask picks the brick.
  always_comb begin
    w_col_hit = 1'b0;
    w_col     = 3'd0;
    for (int c = 0; c < 8; c++) begin
      if (w_xi >= 5 + 35*c && w_xi <= 36 + 35*c) begin
        w_col_hit = 1'b1;
        w_col     = 3'(c);
      end
    end
    w_row_hit = 1'b0;
    w_row     = 3'd0;
    for (int r = 0; r < 6; r++) begin
      if (w_yi >= 32 + 13*r && w_yi <= 40 + 13*r) begin
        w_row_hit = 1'b1;
        w_row     = 3'(r);
      end
    end
  end

  assign w_brick_hit = w_col_hit && w_row_hit && r_bricks[{w_row, w_col}];

  // Digit 0 (thousands) sits in the most significant BCD nibble.
  always_comb begin
    w_digit_lit = 1'b0;
    for (int d = 0; d < 4; d++) begin
      if (w_xi >= 8 + 14*d && w_xi <= 17 + 14*d && w_yi >= 4 && w_yi <= 19) begin
        if (seg_hit(seg_decode(r_bcd[4*(3-d) +: 4]), w_xi - (8 + 14*d), w_yi - 4))
          w_digit_lit = 1'b1;
      end
    end
  end

  always_comb begin
    w_colour = 16'h0000;
    if (w_ball_hit)        w_colour = 16'hFFE0;
    else if (w_paddle_hit) w_colour = 16'hFFFF;
    else if (w_digit_lit)  w_colour = 16'hFFFF;
    else if (w_brick_hit) begin
      if (w_row < 3'd2)      w_colour = 16'hF800;
      else if (w_row < 3'd4) w_colour = 16'hFD20;
      else                   w_colour = 16'h07E0;
    end
    else if (w_yi < 24)    w_colour = r_ball_lost ? 16'h8000 : 16'h2104;
  end

  // Colour derives only from registered state, so it cannot move while the stream stalls.
  assign pix.pix_valid = w_pix_valid;
  assign pix.pix_data  = w_pix_valid ? w_colour : 16'h0000;
  assign pix.pix_first = w_pix_valid && (r_x == '0) && (r_y == '0);
  assign pix.pix_last  = w_pix_valid && w_at_last;

endmodule

// File: tb/tb_breakout_renderer.sv
module tb_breakout_renderer;
  localparam int W = 64;
  localparam int H = 220;
  localparam int N = W * H;

  logic        clk;
  logic        reset_n;
  logic        frame_start;
  logic [8:0]  paddle_x;
  logic [8:0]  ball_x_pix;
  logic [8:0]  ball_y_pix;
  logic [47:0] bricks_alive;
  logic [9:0]  score;
  logic        ball_lost;
  logic        busy;
  logic        frame_done;

  breakout_renderer_if pix_if();

  breakout_renderer #(.GAME_W(W), .GAME_H(H)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .frame_start  (frame_start),
    .paddle_x     (paddle_x),
    .ball_x_pix   (ball_x_pix),
    .ball_y_pix   (ball_y_pix),
    .bricks_alive (bricks_alive),
    .score        (score),
    .ball_lost    (ball_lost),
    .busy         (busy),
    .frame_done   (frame_done),
    .pix          (pix_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;

  // Model snapshot: what the frame being drawn must show.
  int          s_paddle, s_bx, s_by, s_score;
  logic [47:0] s_bricks;
  bit          s_lost;

  string seg_names [10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                            "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};
  int    place [4] = '{1000, 100, 10, 1};

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic bit model_digit(int x, int y);
    int  d, u, v, val;
    bit  hit;
    byte ch;
    hit = 0;
    if (x >= 8 && y >= 4 && y <= 19) begin
      d = (x - 8) / 14;
      u = (x - 8) % 14;
      v = y - 4;
      if (d < 4 && u < 10) begin
        val = (s_score / place[d]) % 10;
        for (int i = 0; i < seg_names[val].len(); i++) begin
          ch = seg_names[val][i];
          if (ch == "a" && v <= 1 && u >= 1 && u <= 8)   hit = 1;
          if (ch == "b" && u >= 8 && v >= 1 && v <= 7)   hit = 1;
          if (ch == "c" && u >= 8 && v >= 8 && v <= 14)  hit = 1;
          if (ch == "d" && v >= 14 && u >= 1 && u <= 8)  hit = 1;
          if (ch == "e" && u <= 1 && v >= 8 && v <= 14)  hit = 1;
          if (ch == "f" && u <= 1 && v >= 1 && v <= 7)   hit = 1;
          if (ch == "g" && (v == 7 || v == 8) && u >= 1 && u <= 8) hit = 1;
        end
      end
    end
    return hit;
  endfunction

  function automatic logic [15:0] model_px(int x, int y);
    int c, r;
    if (x >= s_bx && x <= s_bx + 7 && y >= s_by && y <= s_by + 7) return 16'hFFE0;
    if (x >= s_paddle - 16 && x <= s_paddle + 15 && y >= 210 && y <= 218) return 16'hFFFF;
    if (model_digit(x, y)) return 16'hFFFF;
    if (x >= 5 && y >= 32) begin
      c = (x - 5) / 35;
      r = (y - 32) / 13;
      if (c < 8 && r < 6 && (x - 5) % 35 < 32 && (y - 32) % 13 < 9 && s_bricks[r*8 + c])
        return (r < 2) ? 16'hF800 : (r < 4) ? 16'hFD20 : 16'h07E0;
    end
    if (y < 24) return s_lost ? 16'h8000 : 16'h2104;
    return 16'h0000;
  endfunction

  function automatic int unsigned mix(int unsigned c, logic [15:0] d);
    return ((c << 3) | (c >> 29)) ^ {16'h0, d} ^ 32'h5bd1e995;
  endfunction

  function automatic int unsigned model_sum();
    int unsigned c = 0;
    for (int i = 0; i < N; i++) c = mix(c, model_px(i % W, i / W));
    return c;
  endfunction

  // ---------------- compare process ----------------
  logic [15:0] cap [N];
  int          idx = 0;
  int          done_cnt = 0;
  int unsigned sum = 0;
  int unsigned last_sum = 0;
  logic        prev_stall = 1'b0;
  logic [17:0] prev_out = '0;

  always @(negedge clk) begin
    logic [17:0] got, exp_v;
    got = {pix_if.pix_data, pix_if.pix_first, pix_if.pix_last};
    if (!reset_n) begin
      idx        = 0;
      sum        = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {13'h0, pix_if.pix_valid, got}, {13'h0, 1'b1, prev_out});
      if (pix_if.pix_valid) begin
        if (idx >= N) begin
          checks++;
          errors++;
          $display("FAIL pixel_overrun index=%0d limit=%0d", idx, N);
        end else begin
          exp_v = {model_px(idx % W, idx / W), idx == 0, idx == N - 1};
          check($sformatf("pixel(%0d,%0d)", idx % W, idx / W), {14'h0, got}, {14'h0, exp_v});
          if (pix_if.pix_ready) begin
            cap[idx] = pix_if.pix_data;
            sum      = mix(sum, pix_if.pix_data);
            idx++;
          end
        end
      end
      prev_stall = pix_if.pix_valid && !pix_if.pix_ready;
      prev_out   = got;
      if (frame_done) begin
        check("frame_pixel_count", idx, N);
        done_cnt++;
        last_sum = sum;
        sum      = 0;
        idx      = 0;
      end
    end
  end

  // ---------------- pix_ready driver ----------------
  bit rand_mode = 0;
  initial begin
    pix_if.pix_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      pix_if.pix_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_frame();
    s_paddle = int'(paddle_x);
    s_bx     = int'(ball_x_pix);
    s_by     = int'(ball_y_pix);
    s_score  = int'(score);
    s_bricks = bricks_alive;
    s_lost   = ball_lost;
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic pulse_start_only();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int start, n;
    start = done_cnt;
    n = 0;
    while (!frame_done && n < 40000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, frame_done, 1'b1);
    @(negedge clk);
    check({name, "_done_pulse_width"}, frame_done, 1'b0);
    check({name, "_busy_after"}, busy, 1'b0);
    check({name, "_done_count"}, done_cnt, start + 1);
  endtask

  task automatic chk_px(input string name, input int x, input int y, input logic [15:0] exp);
    check({name, "_dut"}, cap[y*W + x], exp);
    check({name, "_model"}, model_px(x, y), exp);
  endtask

  initial begin
    int lat, n, dc;
    reset_n      = 1'b0;
    frame_start  = 1'b0;
    paddle_x     = 9'd24;
    ball_x_pix   = 9'd20;
    ball_y_pix   = 9'd194;
    bricks_alive = '1;
    score        = 10'd0;
    ball_lost    = 1'b0;
    tick(3);
    @(negedge clk);
    check("reset_outputs",
          {pix_if.pix_valid, pix_if.pix_data, pix_if.pix_first, pix_if.pix_last, busy, frame_done},
          21'h0);
    tick(1);
    reset_n = 1'b1;
    tick(2);

    // Frame 1: ready tied high, score 0, all bricks.
    start_frame();
    @(negedge clk);
    check("busy_after_start", busy, 1'b1);
    lat = 1;
    while (!pix_if.pix_valid && lat <= 20) begin
      @(negedge clk);
      if (!pix_if.pix_valid) lat++;
    end
    check("first_valid_latency_ok", lat <= 16, 1'b1);
    wait_done("f1");
    check("f1_checksum", last_sum, model_sum());
    chk_px("f1_brick_r0", 5, 32, 16'hF800);
    chk_px("f1_brick_r4", 5, 84, 16'h07E0);
    chk_px("f1_brick_r2", 5, 58, 16'hFD20);
    chk_px("f1_brick_c1", 40, 40, 16'hF800);
    chk_px("f1_paddle", 24, 214, 16'hFFFF);
    chk_px("f1_ball", 24, 198, 16'hFFE0);
    chk_px("f1_gap", 4, 32, 16'h0000);
    chk_px("f1_zero_seg_g_off", 12, 11, 16'h2104);

    // Frame 3: score 1023; inputs change the cycle after the request.
    tick(3);
    score = 10'd1023;
    start_frame();
    paddle_x        = 9'd40;
    bricks_alive[0] = 1'b0;
    wait_done("f3");
    chk_px("f3_thousands_seg_a_off", 9, 4, 16'h2104);
    chk_px("f3_thousands_seg_b", 16, 5, 16'hFFFF);
    chk_px("f3_units_seg_g", 54, 11, 16'hFFFF);
    chk_px("f3_old_brick", 5, 32, 16'hF800);
    chk_px("f3_old_paddle", 10, 214, 16'hFFFF);

    // Frame 4: new values, random backpressure.
    tick(3);
    rand_mode = 1;
    start_frame();
    wait_done("f4");
    rand_mode = 0;
    check("f4_checksum", last_sum, model_sum());
    chk_px("f4_brick_dead", 5, 32, 16'h0000);
    chk_px("f4_paddle_moved_off", 10, 214, 16'h0000);
    chk_px("f4_paddle_moved_on", 24, 214, 16'hFFFF);

    // Frame 5: reset at pixel 1000 aborts with no frame_done.
    tick(3);
    start_frame();
    n = 0;
    while (idx < 1000 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("f5_reached_pixel_1000", idx >= 1000, 1'b1);
    dc = done_cnt;
    #2;
    reset_n = 1'b0;
    #1;
    check("f5_async_reset_outputs",
          {pix_if.pix_valid, pix_if.pix_data, pix_if.pix_first, pix_if.pix_last, busy, frame_done},
          21'h0);
    tick(3);
    reset_n = 1'b1;
    tick(20);
    check("f5_no_frame_done", done_cnt, dc);
    check("f5_idle_after_abort", {busy, pix_if.pix_valid}, 2'b00);

    // Frame 6: ball_lost, paddle at left edge, random bricks/score, extra requests ignored.
    ball_lost    = 1'b1;
    paddle_x     = 9'd10;
    ball_x_pix   = 9'd40;
    ball_y_pix   = 9'd150;
    bricks_alive = {16'($urandom), 32'($urandom)};
    score        = 10'($urandom_range(0, 1023));
    dc = done_cnt;
    start_frame();
    tick(500);
    pulse_start_only();
    tick(5000);
    pulse_start_only();
    wait_done("f6");
    tick(30);
    check("f6_single_frame_done", done_cnt, dc + 1);
    check("f6_idle_after", {busy, pix_if.pix_valid}, 2'b00);
    check("f6_checksum", last_sum, model_sum());
    chk_px("f6_lost_hud", 60, 10, 16'h8000);
    chk_px("f6_paddle_left", 0, 214, 16'hFFFF);
    chk_px("f6_paddle_right", 25, 214, 16'hFFFF);
    chk_px("f6_past_paddle", 26, 214, 16'h0000);
    chk_px("f6_no_wrap", 63, 214, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
